acs_pmu: RTL and testbench

ACS_PMU -- requirements
Module: acs_pmu

---
 rtl/acs_pmu_pkg.sv | 37 +++
 rtl/acs_pmu_if.sv | 46 ++++
 rtl/acs_butterfly.sv | 28 ++
 rtl/acs_pmu.sv | 129 ++++++++++++
 tb/tb_acs_pmu.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acs_pmu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acs_pmu_pkg : shared widths, state encoding and branch labels        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package acs_pmu_pkg;

    localparam int PM_W    = 6;
    localparam int PM_INIT = 16;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // Encoder output pair expected on each trellis branch (from_to).
    localparam logic [1:0] LBL_S0_S0 = 2'b00;
    localparam logic [1:0] LBL_S0_S2 = 2'b11;
    localparam logic [1:0] LBL_S1_S0 = 2'b11;
    localparam logic [1:0] LBL_S1_S2 = 2'b00;
    localparam logic [1:0] LBL_S2_S1 = 2'b10;
    localparam logic [1:0] LBL_S2_S3 = 2'b01;
    localparam logic [1:0] LBL_S3_S1 = 2'b01;
    localparam logic [1:0] LBL_S3_S3 = 2'b10;

    // Hard-decision Hamming distance between a received pair and a label.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                 input logic [1:0] label);
        logic [1:0] d;
        d = rx ^ label;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acs_pmu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acs_pmu_if : branch-metric input and decision output bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface acs_pmu_if #(
    parameter int PM_W = acs_pmu_pkg::PM_W
);
    logic            valid_i;
    logic            start_i;
    logic            last_i;
    logic [1:0]      bm_s0_s0_i;
    logic [1:0]      bm_s1_s0_i;
    logic [1:0]      bm_s2_s1_i;
    logic [1:0]      bm_s3_s1_i;
    logic [1:0]      bm_s0_s2_i;
    logic [1:0]      bm_s1_s2_i;
    logic [1:0]      bm_s2_s3_i;
    logic [1:0]      bm_s3_s3_i;
    logic [3:0]      dec_o;
    logic            dec_valid_o;
    logic            last_o;
    logic [1:0]      best_state_o;
    logic [PM_W-1:0] pm0_o;
    logic [PM_W-1:0] pm1_o;
    logic [PM_W-1:0] pm2_o;
    logic [PM_W-1:0] pm3_o;

    modport master (
        output valid_i, start_i, last_i,
        output bm_s0_s0_i, bm_s1_s0_i, bm_s2_s1_i, bm_s3_s1_i,
        output bm_s0_s2_i, bm_s1_s2_i, bm_s2_s3_i, bm_s3_s3_i,
        input  dec_o, dec_valid_o, last_o, best_state_o,
        input  pm0_o, pm1_o, pm2_o, pm3_o
    );

    modport slave (
        input  valid_i, start_i, last_i,
        input  bm_s0_s0_i, bm_s1_s0_i, bm_s2_s1_i, bm_s3_s1_i,
        input  bm_s0_s2_i, bm_s1_s2_i, bm_s2_s3_i, bm_s3_s3_i,
        output dec_o, dec_valid_o, last_o, best_state_o,
        output pm0_o, pm1_o, pm2_o, pm3_o
    );

endinterface
`default_nettype wire

// File: rtl/acs_butterfly.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acs_butterfly : add-compare-select for one trellis state             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module acs_butterfly #(
    parameter int PM_W = 6
) (
    input  wire logic [PM_W-1:0] pm_up,
    input  wire logic [PM_W-1:0] pm_lo,
    input  wire logic [1:0]      bm_up,
    input  wire logic [1:0]      bm_lo,
    output logic      [PM_W:0]   pm_new,
    output logic                 dec
);

    logic [PM_W:0] w_sum_up;
    logic [PM_W:0] w_sum_lo;

    assign w_sum_up = {1'b0, pm_up} + {{(PM_W-1){1'b0}}, bm_up};
    assign w_sum_lo = {1'b0, pm_lo} + {{(PM_W-1){1'b0}}, bm_lo};

    // Strict less-than so a tie keeps the upper predecessor.
    assign dec    = (w_sum_lo < w_sum_up);
    assign pm_new = dec ? w_sum_lo : w_sum_up;

endmodule
`default_nettype wire

// File: rtl/acs_pmu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acs_pmu : 4-state Viterbi ACS with path-metric normalization         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module acs_pmu #(
    parameter int PM_W    = acs_pmu_pkg::PM_W,
    parameter int PM_INIT = acs_pmu_pkg::PM_INIT
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    acs_pmu_if.slave   bus
);
    import acs_pmu_pkg::*;

    localparam logic [PM_W-1:0] HALF_PM = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] INIT_PM = PM_INIT[PM_W-1:0];

    logic [PM_W-1:0] r_pm [4];
    logic [3:0]      r_dec;
    logic            r_dec_valid;
    logic            r_last;
    state_t          r_best;

    logic [PM_W-1:0] w_old   [4];
    logic [1:0]      w_bm_up [4];
    logic [1:0]      w_bm_lo [4];
    logic [PM_W:0]   w_sum   [4];
    logic [3:0]      w_dec;
    logic            w_norm;
    logic [PM_W-1:0] w_new   [4];
    logic [PM_W-1:0] w_min;
    state_t          w_best;

    // A frame start discards whatever the registers hold.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_old[k] = r_pm[k];
        end
        if (bus.start_i) begin
            w_old[0] = '0;
            w_old[1] = INIT_PM;
            w_old[2] = INIT_PM;
            w_old[3] = INIT_PM;
        end
    end

    assign w_bm_up[0] = bus.bm_s0_s0_i;
    assign w_bm_lo[0] = bus.bm_s1_s0_i;
    assign w_bm_up[1] = bus.bm_s2_s1_i;
    assign w_bm_lo[1] = bus.bm_s3_s1_i;
    assign w_bm_up[2] = bus.bm_s0_s2_i;
    assign w_bm_lo[2] = bus.bm_s1_s2_i;
    assign w_bm_up[3] = bus.bm_s2_s3_i;
    assign w_bm_lo[3] = bus.bm_s3_s3_i;

    // Even states are fed by s0/s1, odd states by s2/s3.
    for (genvar k = 0; k < 4; k++) begin : g_bfly
        localparam int UP = (k % 2) * 2;
        acs_butterfly #(
            .PM_W   (PM_W)
        ) u_bfly (
            .pm_up  (w_old[UP]),
            .pm_lo  (w_old[UP+1]),
            .bm_up  (w_bm_up[k]),
            .bm_lo  (w_bm_lo[k]),
            .pm_new (w_sum[k]),
            .dec    (w_dec[k])
        );
    end

    always_comb begin
        w_norm = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (w_sum[k] < {1'b0, HALF_PM}) begin
                w_norm = 1'b0;
            end
        end
        // Metric spread keeps every selected sum below 2^PM_W, so the top bit is always clear.
        for (int k = 0; k < 4; k++) begin
            w_new[k] = w_sum[k][PM_W-1:0] - (w_norm ? HALF_PM : '0);
        end
    end

    always_comb begin
        w_min  = w_new[0];
        w_best = S0;
        for (int k = 1; k < 4; k++) begin
            if (w_new[k] < w_min) begin
                w_min  = w_new[k];
                w_best = state_t'(k[1:0]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pm[0]     <= '0;
            r_pm[1]     <= INIT_PM;
            r_pm[2]     <= INIT_PM;
            r_pm[3]     <= INIT_PM;
            r_dec       <= '0;
            r_dec_valid <= 1'b0;
            r_last      <= 1'b0;
            r_best      <= S0;
        end else begin
            r_dec_valid <= bus.valid_i;
            r_last      <= bus.valid_i & bus.last_i;
            if (bus.valid_i) begin
                for (int k = 0; k < 4; k++) begin
                    r_pm[k] <= w_new[k];
                end
                r_dec  <= w_dec;
                r_best <= w_best;
            end
        end
    end

    assign bus.pm0_o        = r_pm[0];
    assign bus.pm1_o        = r_pm[1];
    assign bus.pm2_o        = r_pm[2];
    assign bus.pm3_o        = r_pm[3];
    assign bus.dec_o        = r_dec;
    assign bus.dec_valid_o  = r_dec_valid;
    assign bus.last_o       = r_last;
    assign bus.best_state_o = r_best;

endmodule
`default_nettype wire

// File: tb/tb_acs_pmu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_acs_pmu : scoreboard bench for the ACS path-metric unit           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_acs_pmu;
    import acs_pmu_pkg::*;

    localparam int W    = acs_pmu_pkg::PM_W;
    localparam int INIT = acs_pmu_pkg::PM_INIT;
    localparam int HALF = 1 << (W - 1);
    // Packed branch metrics, index 0 = s0_s0 ... index 7 = s3_s3.
    localparam logic [15:0] RX00 = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
    localparam logic [15:0] RX11 = {2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};

    typedef struct packed {
        logic [W-1:0] pm3;
        logic [W-1:0] pm2;
        logic [W-1:0] pm1;
        logic [W-1:0] pm0;
        logic [3:0]   dec;
        logic [1:0]   best;
        logic         last;
        logic         norm;
    } exp_t;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;
    int   norm_hits;
    int   mpm [4];
    exp_t m_last;
    exp_t sb [$];

    acs_pmu_if #(.PM_W(W)) bus ();

    acs_pmu #(
        .PM_W    (W),
        .PM_INIT (INIT)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [4*W+6:0] snap();
        return {bus.pm3_o, bus.pm2_o, bus.pm1_o, bus.pm0_o,
                bus.dec_o, bus.best_state_o, bus.last_o};
    endfunction

    function automatic logic [4*W+6:0] exp_snap(input exp_t e);
        return {e.pm3, e.pm2, e.pm1, e.pm0, e.dec, e.best, e.last};
    endfunction

    function automatic logic [15:0] bms_rx(input logic [1:0] rx);
        return {branch_metric(rx, LBL_S3_S3), branch_metric(rx, LBL_S2_S3),
                branch_metric(rx, LBL_S1_S2), branch_metric(rx, LBL_S0_S2),
                branch_metric(rx, LBL_S3_S1), branch_metric(rx, LBL_S2_S1),
                branch_metric(rx, LBL_S1_S0), branch_metric(rx, LBL_S0_S0)};
    endfunction

    function automatic void model_reset();
        mpm    = '{0, INIT, INIT, INIT};
        m_last = '0;
        sb.delete();
    endfunction

    function automatic void model_step(input logic st, input logic la, input logic [15:0] bms);
        int   pred_up [4] = '{0, 2, 0, 2};
        int   old [4];
        int   n [4];
        int   a, b, mn;
        exp_t e;
        e = '0;
        for (int k = 0; k < 4; k++) old[k] = st ? ((k == 0) ? 0 : INIT) : mpm[k];
        for (int k = 0; k < 4; k++) begin
            a = old[pred_up[k]]     + int'(bms[4*k +: 2]);
            b = old[pred_up[k] + 1] + int'(bms[4*k+2 +: 2]);
            e.dec[k] = (b < a);
            n[k]     = (b < a) ? b : a;
        end
        e.norm = (n[0] >= HALF) && (n[1] >= HALF) && (n[2] >= HALF) && (n[3] >= HALF);
        if (e.norm) for (int k = 0; k < 4; k++) n[k] = n[k] - HALF;
        mn = n[0];
        for (int k = 1; k < 4; k++) if (n[k] < mn) begin mn = n[k]; e.best = 2'(k); end
        mpm    = n;
        e.pm0  = W'(n[0]);
        e.pm1  = W'(n[1]);
        e.pm2  = W'(n[2]);
        e.pm3  = W'(n[3]);
        e.last = la;
        m_last = e;
        sb.push_back(e);
    endfunction

    task automatic send(input logic st, input logic la, input logic [15:0] bms);
        bus.valid_i    = 1'b1;
        bus.start_i    = st;
        bus.last_i     = la;
        bus.bm_s0_s0_i = bms[1:0];
        bus.bm_s1_s0_i = bms[3:2];
        bus.bm_s2_s1_i = bms[5:4];
        bus.bm_s3_s1_i = bms[7:6];
        bus.bm_s0_s2_i = bms[9:8];
        bus.bm_s1_s2_i = bms[11:10];
        bus.bm_s2_s3_i = bms[13:12];
        bus.bm_s3_s3_i = bms[15:14];
        model_step(st, la, bms);
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.last_i = 1'b0;
        bus.bm_s0_s0_i = '0; bus.bm_s1_s0_i = '0; bus.bm_s2_s1_i = '0; bus.bm_s3_s1_i = '0;
        bus.bm_s0_s2_i = '0; bus.bm_s1_s2_i = '0; bus.bm_s2_s3_i = '0; bus.bm_s3_s3_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (snap() !== {W'(INIT), W'(INIT), W'(INIT), W'(0), 4'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got pm=%0d/%0d/%0d/%0d dec=%b best=%0d last=%b, want pm=0/%0d/%0d/%0d dec=0000 best=0 last=0",
                     bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, bus.best_state_o, bus.last_o, INIT, INIT, INIT);
        end
        checks++;
        if (bus.dec_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_first_symbols();
        logic [15:0] rx [2];
        logic [4*W+6:0] want [2];
        rx[0]   = RX00;
        rx[1]   = RX11;
        want[0] = {W'(17), W'(2), W'(17), W'(0), 4'b0000, 2'd0, 1'b0};
        want[1] = {W'(3), W'(0), W'(3), W'(2), 4'b0000, 2'd2, 1'b0};
        for (int i = 0; i < 2; i++) begin
            send(i == 0, 1'b0, rx[i]);
            void'(sb.pop_front());
            checks++;
            if (bus.dec_valid_o !== 1'b1 || snap() !== want[i]) begin
                failures++;
                $display("FAIL first_sym[%0d]: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b best=%0d, want valid=1 out=%h",
                         i, bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o,
                         bus.dec_o, bus.best_state_o, want[i]);
            end
        end
    endtask

    task automatic test_normalization();
        exp_t e;
        norm_hits = 0;
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 1'b0, bms_rx(2'($urandom)));
            checks++;
            if (bus.dec_valid_o !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL norm_valid[%0d]: got dec_valid=%b queued=%0d want 1", i, bus.dec_valid_o, sb.size());
                sb.delete();
            end else begin
                e = sb.pop_front();
                checks++;
                if (snap() !== exp_snap(e)) begin
                    failures++;
                    $display("FAIL norm_sym[%0d]: got pm=%0d/%0d/%0d/%0d dec=%b best=%0d, want pm=%0d/%0d/%0d/%0d dec=%b best=%0d (norm=%b)",
                             i, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, bus.best_state_o,
                             e.pm0, e.pm1, e.pm2, e.pm3, e.dec, e.best, e.norm);
                end else if (e.norm) begin
                    norm_hits++;
                end
            end
        end
        checks++;
        if (norm_hits == 0) begin
            failures++;
            $display("FAIL norm_seen: got %0d matching normalization cycles want >0", norm_hits);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, bms_rx(2'($urandom)));
            void'(sb.pop_front());
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (bus.dec_valid_o !== 1'b0 || snap() !== {m_last.pm3, m_last.pm2, m_last.pm1, m_last.pm0, m_last.dec, m_last.best, 1'b0}) begin
                failures++;
                $display("FAIL hold[%0d]: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b, want valid=0 pm=%0d/%0d/%0d/%0d dec=%b",
                         i, bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o,
                         m_last.pm0, m_last.pm1, m_last.pm2, m_last.pm3, m_last.dec);
            end
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, bms_rx(2'($urandom)));
            e = sb.pop_front();
            checks++;
            if (bus.dec_valid_o !== 1'b1 || snap() !== exp_snap(e)) begin
                failures++;
                $display("FAIL hold_resume[%0d]: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b, want valid=1 pm=%0d/%0d/%0d/%0d dec=%b",
                         i, bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o,
                         e.pm0, e.pm1, e.pm2, e.pm3, e.dec);
            end
        end
    endtask

    task automatic test_restart_last();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            send(1'b0, 1'b0, bms_rx(2'($urandom)));
            e = sb.pop_front();
            checks++;
            if (bus.dec_valid_o !== 1'b1 || snap() !== exp_snap(e)) begin
                failures++;
                $display("FAIL restart_pre[%0d]: got pm=%0d/%0d/%0d/%0d dec=%b, want pm=%0d/%0d/%0d/%0d dec=%b",
                         i, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, e.pm0, e.pm1, e.pm2, e.pm3, e.dec);
            end
        end
        send(1'b1, 1'b1, RX00);
        void'(sb.pop_front());
        checks++;
        if (bus.dec_valid_o !== 1'b1 || snap() !== {W'(17), W'(2), W'(17), W'(0), 4'b0000, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b best=%0d last=%b, want valid=1 pm=0/17/2/17 dec=0000 best=0 last=1",
                     bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, bus.best_state_o, bus.last_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (bus.last_o !== 1'b0 || bus.dec_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL last_pulse: got last=%b valid=%b one cycle later, want 0/0", bus.last_o, bus.dec_valid_o);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b0, bms_rx(2'($urandom)));
            e = sb.pop_front();
            checks++;
            if (bus.dec_valid_o !== 1'b1 || snap() !== exp_snap(e)) begin
                failures++;
                $display("FAIL areset_pre[%0d]: got pm=%0d/%0d/%0d/%0d dec=%b, want pm=%0d/%0d/%0d/%0d dec=%b",
                         i, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, e.pm0, e.pm1, e.pm2, e.pm3, e.dec);
            end
        end
        #3 rst_ni = 1'b0;
        #1;
        checks++;
        if (bus.dec_valid_o !== 1'b0 ||
            snap() !== {W'(INIT), W'(INIT), W'(INIT), W'(0), 4'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL areset_now: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b best=%0d last=%b, want valid=0 pm=0/%0d/%0d/%0d dec=0 best=0 last=0",
                     bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o,
                     bus.best_state_o, bus.last_o, INIT, INIT, INIT);
        end
        #2 rst_ni = 1'b1;
        model_reset();
        send(1'b0, 1'b0, RX00);
        void'(sb.pop_front());
        checks++;
        if (bus.dec_valid_o !== 1'b1 || snap() !== {W'(17), W'(2), W'(17), W'(0), 4'b0000, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL areset_first: got valid=%b pm=%0d/%0d/%0d/%0d dec=%b best=%0d, want valid=1 pm=0/17/2/17 dec=0000 best=0",
                     bus.dec_valid_o, bus.pm0_o, bus.pm1_o, bus.pm2_o, bus.pm3_o, bus.dec_o, bus.best_state_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_symbols();
        test_normalization();
        test_hold();
        test_restart_last();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
